// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : 640x480@60 raster timing constants, counter width and the
//             packed hsync/vsync/valid bundle. Shared by the timing generator,
//             the pixel generator and the number-block geometry.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Width of h_cnt / v_cnt; 10 bits covers both totals (800, 525).
  localparam int CNT_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_HS_START  = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_HS_END    = VGA_HS_START + VGA_H_SYNC;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_VS_START  = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_VS_END    = VGA_VS_START + VGA_V_SYNC;

  // DAC-side control bundle, packed as {hs, vs, vd}.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vd;
  } sync_t;

  // Idle (blanked, syncs inactive) value used to fill the delay line at reset.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  // True when lo <= x < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] x,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_delay
//  Purpose  : Fixed-depth shift register for the hsync/vsync/valid bundle so
//             the DAC controls line up with pixel data from 1-cycle RAM reads.
//             DEPTH=0 is a straight wire.
//  Ports    : clk   - system clock
//             rst_n - asynchronous reset, active low (stages load RST_VAL)
//             en    - shift enable (low holds every stage)
//             din   - raw bundle in
//             dout  - bundle delayed by DEPTH enabled clocks
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, en};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing from the system clock: pixel tick divider,
//             h/v counters with line/frame pulses, and hsync/vsync/valid
//             decoded from the counters and delayed by PIPE_DLY clocks.
//  Ports    : clk         - system clock
//             rst_n       - asynchronous reset, active low
//             en          - timing enable; low freezes the raster
//             pclk_en     - one-clock pixel tick every CLK_DIV clocks
//             h_cnt/v_cnt - undelayed raster position
//             line_start  - pulse when h_cnt wraps to 0
//             frame_start - pulse when h_cnt and v_cnt both wrap to 0
//             hsync/vsync - active-low syncs, delayed PIPE_DLY clocks
//             valid       - visible-area flag, delayed PIPE_DLY clocks
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int PIPE_DLY  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pclk_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             valid
);

  // CLK_DIV is at most 16, so the divider never exceeds 15.
  localparam int DIV_W = 4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             tick;
  sync_t            raw;
  sync_t            dly;

  // The tick is the edge on which the counters advance; pclk_en is its
  // registered copy, so it is high in the same clock the new position shows.
  assign tick = en && (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pclk_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
    end else begin
      pclk_en     <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt      <= '0;
          line_start <= 1'b1;
          if (v_cnt == V_LAST) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Raw decode straight from the registered counters.
  always_comb begin
    raw.hs = !in_window(h_cnt, HS_START, HS_END);
    raw.vs = !in_window(v_cnt, VS_START, VS_END);
    raw.vd = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // Shifts every enabled clock (not every tick) so the DAC controls match
  // the clock-level latency of the pixel generator's RAM read.
  vga_sync_delay #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .din  (raw),
    .dout (dly)
  );

  assign hsync = dly.hs;
  assign vsync = dly.vs;
  assign valid = dly.vd;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench. Ten reduced-raster instances sweep
//             PIPE_DLY 0..4 x CLK_DIV {1,4}; one full 640x480 instance
//             (CLK_DIV=4, PIPE_DLY=1) covers line timing, enable pause and
//             mid-line reset. Expected outputs come from the count of enabled
//             clocks since reset, converted to a raster position by plain
//             division.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int NI   = 11;
  localparam int MAIN = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic       pe    [NI];
  logic       ls_a  [NI];
  logic       fs_a  [NI];
  logic       hs_a  [NI];
  logic       vs_a  [NI];
  logic       vd_a  [NI];
  logic [9:0] hc    [NI];
  logic [9:0] vc    [NI];

  int total = 0;
  int bad   = 0;

  // Model state: enabled clock edges since reset and whether the last edge was enabled.
  int n       = 0;
  bit last_en = 1'b0;

  // Statistics gathered during the first run after reset.
  bit stats          = 1'b0;
  int main_hs_low    = 0;
  int main_vd_hi     = 0;
  int main_ls        = 0;
  int main_fs        = 0;
  int s0_vd_hi       = 0;
  int s0_vs_low      = 0;
  int s0_fs          = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 10; g++) begin : g_sweep
      vga_timing_gen #(
        .CLK_DIV  ((g < 5) ? 1 : 4),
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE_DLY (g % 5)
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pclk_en    (pe[g]),
        .h_cnt      (hc[g]),
        .v_cnt      (vc[g]),
        .line_start (ls_a[g]),
        .frame_start(fs_a[g]),
        .hsync      (hs_a[g]),
        .vsync      (vs_a[g]),
        .valid      (vd_a[g])
      );
    end
  endgenerate

  vga_timing_gen u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pclk_en    (pe[MAIN]),
    .h_cnt      (hc[MAIN]),
    .v_cnt      (vc[MAIN]),
    .line_start (ls_a[MAIN]),
    .frame_start(fs_a[MAIN]),
    .hsync      (hs_a[MAIN]),
    .vsync      (vs_a[MAIN]),
    .valid      (vd_a[MAIN])
  );

  // Expected {pclk_en, line_start, frame_start, hsync, vsync, valid, h, v}.
  function automatic logic [25:0] model(input int k);
    int cd, pd, hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, p, h, v, m, ph, pv;
    logic pc, ls, fs, o_hs, o_vs, o_vd;
    if (k == MAIN) begin
      cd = 4; pd = 1; hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33;
    end else begin
      cd = (k < 5) ? 1 : 4; pd = k % 5;
      hv = 16; hf = 2; hsw = 4; hb = 3; vv = 8; vf = 2; vsw = 2; vb = 3;
    end
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = (n / cd) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    pc = last_en && (n > 0) && (n % cd == 0);
    ls = pc && (h == 0);
    fs = ls && (v == 0);
    if (n < pd) begin
      o_hs = 1'b1; o_vs = 1'b1; o_vd = 1'b0;
    end else begin
      m    = ((n - pd) / cd) % (ht * vt);
      ph   = m % ht;
      pv   = m / ht;
      o_hs = !((ph >= hv + hf) && (ph < hv + hf + hsw));
      o_vs = !((pv >= vv + vf) && (pv < vv + vf + vsw));
      o_vd = (ph < hv) && (pv < vv);
    end
    return {pc, ls, fs, o_hs, o_vs, o_vd, 10'(h), 10'(v)};
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic check_all();
    logic [25:0] exp_v, act_v;
    for (int k = 0; k < NI; k++) begin
      exp_v = model(k);
      act_v = {pe[k], ls_a[k], fs_a[k], hs_a[k], vs_a[k], vd_a[k], hc[k], vc[k]};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model inst%0d n=%0d: got {pe,ls,fs,hs,vs,vd}=%b h=%0d v=%0d expected %b h=%0d v=%0d",
                 k, n, act_v[25:20], act_v[19:10], act_v[9:0],
                 exp_v[25:20], exp_v[19:10], exp_v[9:0]);
      end
    end
    if (stats) begin
      if (vc[MAIN] == 10'd0 && hs_a[MAIN] == 1'b0) main_hs_low++;
      if (vc[MAIN] == 10'd0 && vd_a[MAIN] == 1'b1) main_vd_hi++;
      if (ls_a[MAIN]) main_ls++;
      if (fs_a[MAIN]) main_fs++;
      if (n <= 374 && vd_a[0]) s0_vd_hi++;
      if (n <= 374 && !vs_a[0]) s0_vs_low++;
      if (n <= 375 && fs_a[0]) s0_fs++;
    end
  endtask

  // One clock: model sees the edge with the inputs present before it, then
  // inputs change 3 ns after the edge and outputs are sampled on the falling edge.
  task automatic step(input bit e);
    @(posedge clk);
    if (rst_n) begin
      if (en) n++;
      last_en = en;
    end
    #3 en = e;
    @(negedge clk);
    check_all();
  endtask

  // Release reset and pin the first ticks of the main instance.
  task automatic release_and_check(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    check_all();
    chk({tag, "_valid_n0"}, int'(vd_a[MAIN]), 0);
    chk({tag, "_hsync_n0"}, int'(hs_a[MAIN]), 1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1);
      if (i == 1) chk({tag, "_valid_n1"}, int'(vd_a[MAIN]), 1);
      if (i == 3) chk({tag, "_pclk_n3"}, int'(pe[MAIN]), 0);
      if (i == 3) chk({tag, "_h_n3"}, int'(hc[MAIN]), 0);
      if (i == 4) chk({tag, "_pclk_n4"}, int'(pe[MAIN]), 1);
      if (i == 4) chk({tag, "_h_n4"}, int'(hc[MAIN]), 1);
    end
  endtask

  initial begin
    int guard;
    int pulses;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) step(1'b0);
    chk("rst_h", int'(hc[MAIN]), 0);
    chk("rst_v", int'(vc[MAIN]), 0);
    chk("rst_hsync", int'(hs_a[MAIN]), 1);
    chk("rst_vsync", int'(vs_a[MAIN]), 1);
    chk("rst_valid", int'(vd_a[MAIN]), 0);
    chk("rst_pclk", int'(pe[MAIN]), 0);

    stats = 1'b1;
    release_and_check("rel1");

    // Run to h_cnt=123, then pause the raster for 37 clocks.
    guard = 0;
    while (!(hc[MAIN] == 10'd123 && pe[MAIN]) && guard < 2000) begin
      step(1'b1);
      guard++;
    end
    chk("reach_h123", int'(hc[MAIN] == 10'd123), 1);
    pulses = 0;
    step(1'b0);
    for (int i = 0; i < 36; i++) begin
      step(1'b0);
      pulses += int'(pe[MAIN]) + int'(ls_a[MAIN]) + int'(fs_a[MAIN]);
    end
    step(1'b1);
    pulses += int'(pe[MAIN]) + int'(ls_a[MAIN]) + int'(fs_a[MAIN]);
    chk("pause_no_pulses", pulses, 0);
    chk("pause_h_hold", int'(hc[MAIN]), 123);
    chk("pause_valid_hold", int'(vd_a[MAIN]), 1);
    guard = 0;
    while (!pe[MAIN] && guard < 8) begin
      step(1'b1);
      guard++;
    end
    chk("resume_tick_seen", int'(pe[MAIN]), 1);
    chk("resume_h124", int'(hc[MAIN]), 124);

    // Run into line 1 until (700,1), which lies inside the hsync pulse.
    guard = 0;
    while (!(hc[MAIN] == 10'd700 && vc[MAIN] == 10'd1) && guard < 12000) begin
      step(1'b1);
      guard++;
    end
    chk("reach_700_1", int'(hc[MAIN] == 10'd700 && vc[MAIN] == 10'd1), 1);
    stats = 1'b0;
    chk("line0_hsync_low_clks", main_hs_low, 384);
    chk("line0_valid_clks", main_vd_hi, 2597);
    chk("main_line_start_cnt", main_ls, 1);
    chk("main_frame_start_cnt", main_fs, 0);
    chk("small_frame_valid", s0_vd_hi, 128);
    chk("small_frame_vsync_low", s0_vs_low, 50);
    chk("small_frame_start_cnt", s0_fs, 1);
    chk("pre_reset_hsync", int'(hs_a[MAIN]), 0);

    // Asynchronous reset in the middle of a clock period.
    #2 rst_n = 1'b0;
    n = 0;
    last_en = 1'b0;
    #1;
    chk("areset_h", int'(hc[MAIN]), 0);
    chk("areset_v", int'(vc[MAIN]), 0);
    chk("areset_hsync", int'(hs_a[MAIN]), 1);
    chk("areset_vsync", int'(vs_a[MAIN]), 1);
    chk("areset_valid", int'(vd_a[MAIN]), 0);
    chk("areset_pclk", int'(pe[MAIN]), 0);
    repeat (3) step(1'b1);
    release_and_check("rel2");
    repeat (2000) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
